io_sys_update_gen: RTL and testbench

- IO-mapped remote-system-update (RSU) controller, parametrised successor of the fixed-width update blocks.
- Sits between the IO bus (AIoAddr/AIoMosi/AIoMiso) and an external RSU IP, driven through ports so any flash variant can be attached.
- After reset it runs a boot sequence: read the RSU state, derive the mode, read the boot address, then raise ready.
- Then serves host parameter read/write operations with busy handshake, timeout detection and an optional watchdog.

---
 rtl/io_sys_update_pkg.sv | 49 ++++
 rtl/io_sys_update_dec.sv | 50 +++++
 rtl/io_sys_update_gen.sv | 232 +++++++++++++++++++++++
 tb/tb_io_sys_update_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_sys_update_pkg.sv
// Shared constants for the IO-mapped remote-system-update controller:
// FSM state codes, register offsets, bus size encodings and status bit positions.
package io_sys_update_pkg;

   localparam logic [3:0] StIdle    = 4'd0;
   localparam logic [3:0] StBStIss  = 4'd1;
   localparam logic [3:0] StBStWait = 4'd2;
   localparam logic [3:0] StBStCapt = 4'd3;
   localparam logic [3:0] StBMode   = 4'd4;
   localparam logic [3:0] StBAdIss  = 4'd5;
   localparam logic [3:0] StBAdWait = 4'd6;
   localparam logic [3:0] StBAdCapt = 4'd7;
   localparam logic [3:0] StReady   = 4'd8;
   localparam logic [3:0] StHIss    = 4'd9;
   localparam logic [3:0] StHWait   = 4'd10;
   localparam logic [3:0] StHCapt   = 4'd11;

   localparam logic [2:0] COffCtrl  = 3'd0;
   localparam logic [2:0] COffOper  = 3'd1;
   localparam logic [2:0] COffParam = 3'd2;
   localparam logic [2:0] COffBoot  = 3'd4;

   // One-hot transfer sizes, bit order {Q,D,W,B}
   localparam logic [3:0] CSizeB = 4'b0001;
   localparam logic [3:0] CSizeW = 4'b0010;
   localparam logic [3:0] CSizeD = 4'b0100;
   localparam logic [3:0] CSizeQ = 4'b1000;

   localparam int CStBusy  = 0;
   localparam int CStReady = 1;
   localparam int CStTmo   = 2;
   localparam int CStOvr   = 3;

   typedef struct packed {
      logic ctrlWr;
      logic statRd;
      logic operWr;
      logic parWr;
      logic parRd;
      logic dataWr;
      logic dataRd;
      logic bootRd;
   } ioStrobe_t;

   function automatic logic isWaitState(input logic [3:0] st);
      return (st == StBStWait) || (st == StBAdWait) || (st == StHWait);
   endfunction

endpackage

// File: rtl/io_sys_update_dec.sv
// Combinational IO window/size decoder: one strobe per supported register access,
// plus AddrAck for a supported hit and AddrErr for an in-window unsupported size.
module io_sys_update_dec
   import io_sys_update_pkg::*;
#(
   parameter logic [15:0] CAddrBase = 16'h0000
)(
   input  logic [15:0] AIoAddr,
   input  logic [3:0]  AIoWrSize,
   input  logic [3:0]  AIoRdSize,
   output ioStrobe_t   AStrobe,
   output logic        AIoAddrAck,
   output logic        AIoAddrErr
);

   logic [15:0] offs;
   logic        inWin;
   logic [2:0]  regOff;
   logic        wrB, wrD, rdB, rdD;
   logic        access;

   assign offs   = AIoAddr - CAddrBase;
   assign inWin  = (offs[15:3] == 13'd0);
   assign regOff = offs[2:0];

   assign wrB = (AIoWrSize == CSizeB);
   assign wrD = (AIoWrSize == CSizeD);
   assign rdB = (AIoRdSize == CSizeB);
   assign rdD = (AIoRdSize == CSizeD);

   // Only well-formed one-hot sizes count as an access; anything else is ignored
   assign access = (AIoWrSize inside {CSizeB, CSizeW, CSizeD, CSizeQ}) ||
                   (AIoRdSize inside {CSizeB, CSizeW, CSizeD, CSizeQ});

   always_comb begin
      AStrobe        = '0;
      AStrobe.ctrlWr = inWin && (regOff == COffCtrl)  && wrB;
      AStrobe.statRd = inWin && (regOff == COffCtrl)  && rdB;
      AStrobe.operWr = inWin && (regOff == COffOper)  && wrB;
      AStrobe.parWr  = inWin && (regOff == COffParam) && wrB;
      AStrobe.parRd  = inWin && (regOff == COffParam) && rdB;
      AStrobe.dataWr = inWin && (regOff == COffParam) && wrD;
      AStrobe.dataRd = inWin && (regOff == COffParam) && rdD;
      AStrobe.bootRd = inWin && (regOff == COffBoot)  && rdD;
   end

   assign AIoAddrAck = |AStrobe;
   assign AIoAddrErr = inWin && access && !AIoAddrAck;

endmodule

// File: rtl/io_sys_update_gen.sv
// Remote-system-update controller: boot sequence (state, mode, boot address) then host
// parameter access with busy/timeout handling. Watchdog kick built only with IO_SYS_UPDATE_WDT_EN.
module io_sys_update_gen
   import io_sys_update_pkg::*;
#(
   parameter logic [15:0] CAddrBase  = 16'h0000,
   parameter int          CDataW     = 32,
   parameter int          CTmoW      = 12,
   parameter logic [2:0]  CAddrParam = 3'h4,
   parameter int          CWdtW      = 8
)(
   input  logic              AClkH,
   input  logic              AResetH,
   input  logic              AClkHEn,
   input  logic [15:0]       AIoAddr,
   input  logic [63:0]       AIoMosi,
   output logic [63:0]       AIoMiso,
   input  logic [3:0]        AIoWrSize,
   input  logic [3:0]        AIoRdSize,
   output logic              AIoAddrAck,
   output logic              AIoAddrErr,
   output logic              AIoBusy,
   output logic [2:0]        ARsuParam,
   output logic [1:0]        ARsuSrc,
   output logic              ARsuRdParam,
   output logic              ARsuWrParam,
   output logic [CDataW-1:0] ARsuDataO,
   input  logic [CDataW-1:0] ARsuDataI,
   input  logic              ARsuBusy,
   output logic              ARsuReconfig,
   output logic              ARsuResetTimer,
   output logic              ARsuReady,
   output logic [31:0]       ARsuBootAddr,
   output logic [1:0]        ARsuMode,
   output logic [7:0]        ATest
);

   ioStrobe_t strobe;

   logic [3:0]        stateReg, stateNext;
   logic              readyReg, ovrErrReg, tmoErrReg, reconfigReg;
   logic [1:0]        modeReg;
   logic [CDataW-3:0] bootAddrReg;
   logic [CDataW-1:0] dataIReg, dataOReg, snapData;
   logic [2:0]        paramReg, snapParam;
   logic [1:0]        srcReg, snapSrc;
   logic              snapRd, snapWr;
   logic [CTmoW-1:0]  tmoCnt;
   logic              tmoFlag;

   logic              busyFlag, tmoFull, waitDone, tmoSet;
   logic              operBusy, operAccept;
   logic [7:0]        statusVec;
   logic              unusedBits;

   io_sys_update_dec #(
      .CAddrBase (CAddrBase)
   ) uDec (
      .AIoAddr    (AIoAddr),
      .AIoWrSize  (AIoWrSize),
      .AIoRdSize  (AIoRdSize),
      .AStrobe    (strobe),
      .AIoAddrAck (AIoAddrAck),
      .AIoAddrErr (AIoAddrErr)
   );

   assign busyFlag = (stateReg != StIdle);
   assign tmoFull  = &tmoCnt;
   // Count 0 is the first wait cycle, so requiring a nonzero count enforces two cycles minimum
   assign waitDone = (tmoCnt != '0) && !ARsuBusy;
   assign tmoSet   = isWaitState(stateReg) && tmoFull && !waitDone;

   assign operBusy   = strobe.operWr && (busyFlag || !readyReg);
   assign operAccept = strobe.operWr && !operBusy && (AIoMosi[0] || AIoMosi[1]);
   assign AIoBusy    = operBusy && !AResetH;

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         StIdle: begin
            if (!readyReg)       stateNext = StBStIss;
            else if (operAccept) stateNext = StHIss;
         end
         StBStIss:  stateNext = StBStWait;
         StBStWait: if (waitDone || tmoFull) stateNext = StBStCapt;
         StBStCapt: stateNext = StBMode;
         StBMode:   stateNext = StBAdIss;
         StBAdIss:  stateNext = StBAdWait;
         StBAdWait: if (waitDone || tmoFull) stateNext = StBAdCapt;
         StBAdCapt: stateNext = StReady;
         StReady:   stateNext = StIdle;
         StHIss:    stateNext = StHWait;
         StHWait: begin
            if (waitDone)     stateNext = StHCapt;
            else if (tmoFull) stateNext = StIdle;
         end
         StHCapt:   stateNext = StIdle;
         default:   stateNext = StIdle;
      endcase
   end

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         stateReg    <= StIdle;
         readyReg    <= 1'b0;
         ovrErrReg   <= 1'b0;
         tmoErrReg   <= 1'b0;
         reconfigReg <= 1'b0;
         modeReg     <= '0;
         bootAddrReg <= '0;
         dataIReg    <= '0;
         dataOReg    <= '0;
         snapData    <= '0;
         paramReg    <= '0;
         snapParam   <= '0;
         srcReg      <= '0;
         snapSrc     <= '0;
         snapRd      <= 1'b0;
         snapWr      <= 1'b0;
         tmoCnt      <= '0;
         tmoFlag     <= 1'b0;
      end else if (AClkHEn) begin
         stateReg <= stateNext;

         if (strobe.ctrlWr) reconfigReg <= AIoMosi[0];
         if (strobe.parWr) begin
            paramReg <= AIoMosi[2:0];
            srcReg   <= AIoMosi[5:4];
         end
         if (strobe.dataWr) dataOReg <= AIoMosi[CDataW-1:0];

         // Freeze the operands so later register writes cannot disturb the access in flight
         if (operAccept) begin
            snapParam <= paramReg;
            snapSrc   <= srcReg;
            snapData  <= dataOReg;
            snapRd    <= AIoMosi[0];
            snapWr    <= AIoMosi[1];
         end

         if (operBusy)           ovrErrReg <= 1'b1;
         else if (strobe.statRd) ovrErrReg <= 1'b0;
         if (tmoSet)             tmoErrReg <= 1'b1;
         else if (strobe.statRd) tmoErrReg <= 1'b0;

         case (stateReg)
            StBStIss, StBAdIss, StHIss: begin
               tmoCnt  <= '0;
               tmoFlag <= 1'b0;
            end
            StBStWait, StBAdWait, StHWait: begin
               tmoCnt <= tmoCnt + CTmoW'(1);
               if (tmoSet) tmoFlag <= 1'b1;
            end
            StBStCapt: modeReg     <= tmoFlag ? 2'b00 : ARsuDataI[1:0];
            StBAdCapt: bootAddrReg <= tmoFlag ? '0 : ARsuDataI[CDataW-1:2];
            StReady:   readyReg    <= 1'b1;
            StHCapt:   if (snapRd) dataIReg <= ARsuDataI;
            default: ;
         endcase
      end
   end

`ifdef IO_SYS_UPDATE_WDT_EN
   logic             wdtEnReg;
   logic [CWdtW-1:0] wdtCnt;

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         wdtEnReg <= 1'b0;
         wdtCnt   <= '0;
      end else if (AClkHEn) begin
         if (strobe.ctrlWr) wdtEnReg <= AIoMosi[1];
         if (strobe.ctrlWr && AIoMosi[1]) wdtCnt <= '0;
         else if (wdtEnReg)               wdtCnt <= wdtCnt + CWdtW'(1);
         else                             wdtCnt <= '0;
      end
   end

   assign ARsuResetTimer = wdtCnt[CWdtW-1];
`else
   assign ARsuResetTimer = 1'b0;
`endif

   always_comb begin
      ARsuParam = paramReg;
      ARsuSrc   = srcReg;
      ARsuDataO = dataOReg;
      case (stateReg)
         StBStIss, StBStWait, StBStCapt: begin
            ARsuParam = 3'd0;
            ARsuSrc   = 2'd0;
         end
         StBAdIss, StBAdWait, StBAdCapt: begin
            ARsuParam = CAddrParam;
            ARsuSrc   = (modeReg == 2'd0) ? 2'd0 : 2'd2;
         end
         StHIss, StHWait, StHCapt: begin
            ARsuParam = snapParam;
            ARsuSrc   = snapSrc;
            ARsuDataO = snapData;
         end
         default: ;
      endcase
   end

   assign ARsuRdParam = (stateReg == StBStIss) || (stateReg == StBAdIss) ||
                        ((stateReg == StHIss) && snapRd);
   assign ARsuWrParam = (stateReg == StHIss) && snapWr;

   assign ARsuReady    = readyReg;
   assign ARsuMode     = modeReg;
   assign ARsuReconfig = reconfigReg;
   assign ARsuBootAddr = {{(34-CDataW){1'b0}}, bootAddrReg};
   assign ATest        = {ARsuRdParam, ARsuBusy, ARsuSrc, readyReg, ARsuParam};

   always_comb begin
      statusVec          = '0;
      statusVec[CStBusy] = busyFlag;
      statusVec[CStReady]= readyReg;
      statusVec[CStTmo]  = tmoErrReg;
      statusVec[CStOvr]  = ovrErrReg;
      AIoMiso = '0;
      if (strobe.statRd)      AIoMiso = {56'd0, statusVec};
      else if (strobe.parRd)  AIoMiso = {56'd0, 2'b00, srcReg, 1'b0, paramReg};
      else if (strobe.dataRd) AIoMiso = 64'(dataIReg);
      else if (strobe.bootRd) AIoMiso = {32'd0, ARsuBootAddr};
   end

   assign unusedBits = ^{AIoMosi[63:CDataW], (CWdtW == 0)};

endmodule

// File: tb/tb_io_sys_update_gen.sv
// Scoreboard bench for io_sys_update_gen: expected RSU strobes and IO reads are queued
// by the stimulus and compared by a negedge monitor; a stub models the RSU IP.
module tb_io_sys_update_gen;
   import io_sys_update_pkg::*;

   localparam logic [15:0] Base = 16'h0100;

   logic        AClkH = 1'b0;
   logic        AResetH = 1'b1;
   logic        AClkHEn = 1'b1;
   logic [15:0] AIoAddr = '0;
   logic [63:0] AIoMosi = '0;
   logic [63:0] AIoMiso;
   logic [3:0]  AIoWrSize = '0;
   logic [3:0]  AIoRdSize = '0;
   logic        AIoAddrAck, AIoAddrErr, AIoBusy;
   logic [2:0]  ARsuParam;
   logic [1:0]  ARsuSrc;
   logic        ARsuRdParam, ARsuWrParam;
   logic [31:0] ARsuDataO;
   logic [31:0] ARsuDataI = '0;
   logic        ARsuBusy = 1'b0;
   logic        ARsuReconfig, ARsuResetTimer, ARsuReady;
   logic [31:0] ARsuBootAddr;
   logic [1:0]  ARsuMode;
   logic [7:0]  ATest;

   io_sys_update_gen #(
      .CAddrBase (Base),
      .CDataW    (32),
      .CTmoW     (4),
      .CAddrParam(3'h4),
      .CWdtW     (4)
   ) dut (
      .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
      .AIoAddr(AIoAddr), .AIoMosi(AIoMosi), .AIoMiso(AIoMiso),
      .AIoWrSize(AIoWrSize), .AIoRdSize(AIoRdSize),
      .AIoAddrAck(AIoAddrAck), .AIoAddrErr(AIoAddrErr), .AIoBusy(AIoBusy),
      .ARsuParam(ARsuParam), .ARsuSrc(ARsuSrc),
      .ARsuRdParam(ARsuRdParam), .ARsuWrParam(ARsuWrParam),
      .ARsuDataO(ARsuDataO), .ARsuDataI(ARsuDataI), .ARsuBusy(ARsuBusy),
      .ARsuReconfig(ARsuReconfig), .ARsuResetTimer(ARsuResetTimer),
      .ARsuReady(ARsuReady), .ARsuBootAddr(ARsuBootAddr),
      .ARsuMode(ARsuMode), .ATest(ATest)
   );

   always #5 AClkH = ~AClkH;

   typedef struct packed {
      logic        wr;
      logic [2:0]  param;
      logic [1:0]  src;
      logic [31:0] data;
   } strbExp_t;

   strbExp_t    strbQ[$];
   logic [63:0] rdQ[$];
   logic [31:0] stubQ[$];
   int          checks = 0;
   int          errors = 0;
   int          rdCount = 0;
   int          busyCnt = 0;
   logic        stuck = 1'b0;
   int          rdBase;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // RSU IP stub: busy for three cycles after each strobe, or forever when stuck
   always @(negedge AClkH) begin
      if (ARsuRdParam || ARsuWrParam) begin
         if (ARsuRdParam) begin
            rdCount++;
            if (stubQ.size() != 0) ARsuDataI = stubQ.pop_front();
         end
         busyCnt  = 2;
         ARsuBusy = 1'b1;
      end else if (busyCnt != 0) begin
         busyCnt--;
      end else begin
         ARsuBusy = stuck;
      end
   end

   // Monitor: every RSU strobe and every acknowledged IO read consumes one expectation
   always @(negedge AClkH) begin
      if (!AResetH) begin
         if (ARsuRdParam || ARsuWrParam) begin
            if (strbQ.size() == 0) begin
               check("rsu strobe unexpected", {ARsuWrParam, ARsuRdParam, ARsuParam, ARsuSrc}, 64'h0);
            end else begin
               strbExp_t e;
               e = strbQ.pop_front();
               check("rsu strobe",
                     {ARsuWrParam, ARsuRdParam, ARsuParam, ARsuSrc, (ARsuWrParam ? ARsuDataO : 32'h0)},
                     {e.wr, !e.wr, e.param, e.src, (e.wr ? e.data : 32'h0)});
            end
         end
         if (AIoAddrAck && (AIoRdSize != 4'h0)) begin
            if (rdQ.size() == 0) check("io read unexpected", AIoMiso, 64'hDEAD);
            else                 check($sformatf("io read @%h", AIoAddr), AIoMiso, rdQ.pop_front());
         end
      end
   end

   task automatic expStrb(input logic wr, input logic [2:0] p, input logic [1:0] s, input logic [31:0] d);
      strbQ.push_back('{wr, p, s, d});
   endtask

   task automatic ioWr(input logic [15:0] addr, input logic [63:0] data, input logic [3:0] size,
                       input logic expBusy);
      AIoAddr   = addr;
      AIoMosi   = data;
      AIoWrSize = size;
      @(negedge AClkH);
      check($sformatf("AIoBusy wr @%h=%h", addr, data), AIoBusy, expBusy);
      @(posedge AClkH);
      #1;
      AIoWrSize = '0;
   endtask

   task automatic ioRd(input logic [15:0] addr, input logic [3:0] size, input logic [63:0] exp);
      rdQ.push_back(exp);
      AIoAddr   = addr;
      AIoRdSize = size;
      @(posedge AClkH);
      #1;
      AIoRdSize = '0;
   endtask

   task automatic probe(input string name, input logic [15:0] addr, input logic [3:0] wr,
                        input logic [3:0] rd, input logic expAck, input logic expErr,
                        input logic [63:0] expMiso);
      AIoAddr   = addr;
      AIoMosi   = '0;
      AIoWrSize = wr;
      AIoRdSize = rd;
      @(negedge AClkH);
      check({name, " ack"}, AIoAddrAck, expAck);
      check({name, " err"}, AIoAddrErr, expErr);
      check({name, " miso"}, AIoMiso, expMiso);
      @(posedge AClkH);
      #1;
      AIoWrSize = '0;
      AIoRdSize = '0;
   endtask

   task automatic waitReady();
      int n;
      n = 0;
      while (!ARsuReady && n < 300) begin
         @(posedge AClkH);
         #1;
         n++;
      end
      check("boot ready", ARsuReady, 1'b1);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge AClkH);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Boot with a responsive RSU: state 1 then address 0x0040_0003
      stubQ.push_back(32'h0000_0001);
      stubQ.push_back(32'h0040_0003);
      expStrb(1'b0, 3'd0, 2'd0, 32'h0);
      expStrb(1'b0, 3'd4, 2'd2, 32'h0);
      rdBase = rdCount;
      cycles(3);
      probe("status in reset", Base, 4'h0, CSizeB, 1'b1, 1'b0, 64'h0);
      check("ready in reset", ARsuReady, 1'b0);
      check("bootaddr in reset", ARsuBootAddr, 32'h0);
      AResetH = 1'b0;

      // Oper write while not yet ready is rejected
      ioWr(Base + 16'd1, 64'h01, CSizeB, 1'b1);
      waitReady();
      check("boot mode", ARsuMode, 2'd1);
      check("boot addr", ARsuBootAddr, 32'h0010_0000);
      check("boot read count", rdCount - rdBase, 2);
      ioRd(Base, CSizeB, 64'h0A);
      ioRd(Base, CSizeB, 64'h02);
      ioRd(Base + 16'd4, CSizeD, 64'h0010_0000);
      ioRd(Base + 16'd2, CSizeD, 64'h0);

      // Host write then host read
      ioWr(Base + 16'd2, 64'h25, CSizeB, 1'b0);
      ioWr(Base + 16'd2, 64'hA5A5_0000, CSizeD, 1'b0);
      expStrb(1'b1, 3'd5, 2'd2, 32'hA5A5_0000);
      ioWr(Base + 16'd1, 64'h02, CSizeB, 1'b0);
      cycles(10);
      ioRd(Base, CSizeB, 64'h02);
      ioRd(Base + 16'd2, CSizeB, 64'h25);
      stubQ.push_back(32'hDEAD_BEEF);
      expStrb(1'b0, 3'd5, 2'd2, 32'h0);
      ioWr(Base + 16'd1, 64'h01, CSizeB, 1'b0);
      cycles(10);
      ioRd(Base + 16'd2, CSizeD, 64'hDEAD_BEEF);

      // Param write during issue does not alter the strobe; Oper during wait is rejected
      expStrb(1'b1, 3'd5, 2'd2, 32'hA5A5_0000);
      ioWr(Base + 16'd1, 64'h02, CSizeB, 1'b0);
      ioWr(Base + 16'd2, 64'h13, CSizeB, 1'b0);
      ioWr(Base + 16'd1, 64'h01, CSizeB, 1'b1);
      ioRd(Base, CSizeB, 64'h0B);
      cycles(10);
      ioRd(Base, CSizeB, 64'h02);
      ioRd(Base + 16'd2, CSizeB, 64'h13);
      ioWr(Base + 16'd1, 64'h00, CSizeB, 1'b0);
      cycles(3);
      ioRd(Base, CSizeB, 64'h02);

      // Decoder boundaries
      probe("byte rd +4", Base + 16'd4, 4'h0, CSizeB, 1'b0, 1'b1, 64'h0);
      probe("word wr +0", Base, CSizeW, 4'h0, 1'b0, 1'b1, 64'h0);
      probe("rd +8", Base + 16'd8, 4'h0, CSizeD, 1'b0, 1'b0, 64'h0);
      probe("rd base-1", Base - 16'd1, 4'h0, CSizeB, 1'b0, 1'b0, 64'h0);

      // Reconfig and watchdog
      ioWr(Base, 64'h01, CSizeB, 1'b0);
      check("reconfig set", ARsuReconfig, 1'b1);
`ifdef IO_SYS_UPDATE_WDT_EN
      ioWr(Base, 64'h02, CSizeB, 1'b0);
      check("reconfig cleared", ARsuReconfig, 1'b0);
      cycles(7);
      check("wdt before 8", ARsuResetTimer, 1'b0);
      cycles(1);
      check("wdt at 8", ARsuResetTimer, 1'b1);
      ioWr(Base, 64'h00, CSizeB, 1'b0);
      check("wdt disabled", ARsuResetTimer, 1'b0);
      ioWr(Base, 64'h02, CSizeB, 1'b0);
      cycles(4);
      ioWr(Base, 64'h02, CSizeB, 1'b0);
      cycles(7);
      check("wdt restart before 8", ARsuResetTimer, 1'b0);
      cycles(1);
      check("wdt restart at 8", ARsuResetTimer, 1'b1);
`else
      ioWr(Base, 64'h02, CSizeB, 1'b0);
      check("reconfig cleared", ARsuReconfig, 1'b0);
      cycles(20);
      check("wdt absent", ARsuResetTimer, 1'b0);
`endif
      ioWr(Base, 64'h00, CSizeB, 1'b0);

      // Stuck RSU: both boot waits time out, data forced to zero
      stuck = 1'b1;
      stubQ.push_back(32'hFFFF_FFFF);
      stubQ.push_back(32'hFFFF_FFFF);
      expStrb(1'b0, 3'd0, 2'd0, 32'h0);
      expStrb(1'b0, 3'd4, 2'd0, 32'h0);
      AResetH = 1'b1;
      cycles(2);
      check("ready cleared by reset", ARsuReady, 1'b0);
      AResetH = 1'b0;
      waitReady();
      check("tmo mode", ARsuMode, 2'd0);
      check("tmo boot addr", ARsuBootAddr, 32'h0);
      ioRd(Base, CSizeB, 64'h06);
      ioRd(Base, CSizeB, 64'h02);
      stubQ.push_back(32'h1234_5678);
      expStrb(1'b0, 3'd0, 2'd0, 32'h0);
      ioWr(Base + 16'd1, 64'h01, CSizeB, 1'b0);
      cycles(25);
      ioRd(Base, CSizeB, 64'h06);
      ioRd(Base + 16'd2, CSizeD, 64'h0);
      stuck = 1'b0;

      cycles(5);
      check("strobe queue drained", strbQ.size(), 0);
      check("read queue drained", rdQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
